// File: rtl/ipif_mst_cmd_arbiter_if.sv
// Command-side bundle between the user-logic requesters, the arbiter and the
// AXI master IPIF. The "master" modport is the arbiter's view (it masters the
// IPIF command channel); "slave" is the surrounding requesters + IPIF view.
interface ipif_mst_cmd_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 20
);
    // requester side
    logic [NUM_REQ-1:0]            req_rd;
    logic [NUM_REQ-1:0]            req_wr;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*LEN_WIDTH-1:0]  req_len;
    logic [NUM_REQ-1:0]            grant;
    logic [NUM_REQ-1:0]            done;
    logic [NUM_REQ-1:0]            err;

    // IPIF master command side
    logic                          ip2bus_mstrd_req;
    logic                          ip2bus_mstwr_req;
    logic [ADDR_WIDTH-1:0]         ip2bus_mst_addr;
    logic [LEN_WIDTH-1:0]          ip2bus_mst_length;
    logic                          bus2ip_mst_cmdack;
    logic                          bus2ip_mst_cmplt;
    logic                          bus2ip_mst_error;

    // status
    logic                          busy;

    modport master (
        input  req_rd, req_wr, req_addr, req_len,
        output grant, done, err,
        output ip2bus_mstrd_req, ip2bus_mstwr_req, ip2bus_mst_addr, ip2bus_mst_length,
        input  bus2ip_mst_cmdack, bus2ip_mst_cmplt, bus2ip_mst_error,
        output busy
    );

    modport slave (
        output req_rd, req_wr, req_addr, req_len,
        input  grant, done, err,
        input  ip2bus_mstrd_req, ip2bus_mstwr_req, ip2bus_mst_addr, ip2bus_mst_length,
        output bus2ip_mst_cmdack, bus2ip_mst_cmplt, bus2ip_mst_error,
        input  busy
    );
endinterface

// File: rtl/ipif_mst_cmd_arbiter.sv
// Round-robin arbiter sharing the single AXI master IPIF command channel
// between NUM_REQ requesters. Latches the winner's address/length/direction,
// runs the IPIF req/ack/complete handshake and returns a one-cycle done
// (and err on bus error) pulse to the owner.
// Optional command watchdog: define IPIF_ARB_WATCHDOG_EN (adds wd_fired port).
module ipif_mst_cmd_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int LEN_WIDTH      = 20,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clock,
    input  logic                  reset,
    ipif_mst_cmd_arbiter_if.master bus
`ifdef IPIF_ARB_WATCHDOG_EN
    ,
    output logic                  wd_fired
`endif
);

    localparam int PTR_W = $clog2(NUM_REQ);
    typedef logic [PTR_W-1:0] ptr_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_CMPLT,
        FINISH
    } state_t;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("ipif_mst_cmd_arbiter: parameter out of range");
    end

    state_t                state_q, state_d;
    logic [NUM_REQ-1:0]    grant_q, grant_d;
    logic [NUM_REQ-1:0]    done_q,  done_d;
    logic [NUM_REQ-1:0]    err_q,   err_d;
    logic                  rd_q,    rd_d;
    logic                  wr_q,    wr_d;
    logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic [LEN_WIDTH-1:0]  len_q,   len_d;
    ptr_t                  rr_q,    rr_d;

    logic [NUM_REQ-1:0]    pending;
    logic                  win_found;
    ptr_t                  win_idx;
    ptr_t                  win_next;
    int unsigned           cand;
    int unsigned           next_ptr;

    logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
    logic [LEN_WIDTH-1:0]  len_arr  [NUM_REQ];

`ifdef IPIF_ARB_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [WD_W-1:0]       wd_cnt_q, wd_cnt_d;
    logic                  wd_fired_q, wd_fired_d;
    logic                  wd_expired;

    assign wd_expired = (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));
    assign wd_fired   = wd_fired_q;
`endif

    // Unpack the flat per-requester address/length buses into arrays.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_arr[i] = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign len_arr[i]  = bus.req_len[i*LEN_WIDTH +: LEN_WIDTH];
    end

    // Round-robin search: first pending requester at or after rr_ptr, wrapping.
    always_comb begin
        pending   = bus.req_rd | bus.req_wr;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = (32'(rr_q) + k) % NUM_REQ;
            if (!win_found && pending[ptr_t'(cand)]) begin
                win_found = 1'b1;
                win_idx   = ptr_t'(cand);
            end
        end
        next_ptr = (32'(win_idx) + 1) % NUM_REQ;
        win_next = ptr_t'(next_ptr);
    end

    // Next-state and next-output logic for the command handshake.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        done_d  = '0;
        err_d   = '0;
        rd_d    = rd_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        len_d   = len_q;
        rr_d    = rr_q;
`ifdef IPIF_ARB_WATCHDOG_EN
        wd_cnt_d   = wd_cnt_q;
        wd_fired_d = wd_fired_q;
`endif
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d          = ISSUE;
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    addr_d           = addr_arr[win_idx];
                    len_d            = len_arr[win_idx];
                    // read takes priority when a requester raises both
                    rd_d             = bus.req_rd[win_idx];
                    wr_d             = ~bus.req_rd[win_idx];
                    rr_d             = win_next;
`ifdef IPIF_ARB_WATCHDOG_EN
                    wd_cnt_d         = '0;
`endif
                end
            end
            ISSUE: begin
                if (bus.bus2ip_mst_cmdack) begin
                    rd_d = 1'b0;
                    wr_d = 1'b0;
                    if (bus.bus2ip_mst_cmplt) begin
                        state_d = FINISH;
                        done_d  = grant_q;
                        err_d   = grant_q & {NUM_REQ{bus.bus2ip_mst_error}};
                    end else begin
                        state_d = WAIT_CMPLT;
`ifdef IPIF_ARB_WATCHDOG_EN
                        wd_cnt_d = '0;
`endif
                    end
                end
`ifdef IPIF_ARB_WATCHDOG_EN
                else if (wd_expired) begin
                    rd_d       = 1'b0;
                    wr_d       = 1'b0;
                    state_d    = FINISH;
                    done_d     = grant_q;
                    err_d      = grant_q;
                    wd_fired_d = 1'b1;
                end else begin
                    wd_cnt_d = wd_cnt_q + 1'b1;
                end
`endif
            end
            WAIT_CMPLT: begin
                if (bus.bus2ip_mst_cmplt) begin
                    state_d = FINISH;
                    done_d  = grant_q;
                    err_d   = grant_q & {NUM_REQ{bus.bus2ip_mst_error}};
                end
`ifdef IPIF_ARB_WATCHDOG_EN
                else if (wd_expired) begin
                    state_d    = FINISH;
                    done_d     = grant_q;
                    err_d      = grant_q;
                    wd_fired_d = 1'b1;
                end else begin
                    wd_cnt_d = wd_cnt_q + 1'b1;
                end
`endif
            end
            FINISH: begin
                grant_d = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; synchronous active-low reset clears everything.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            done_q  <= '0;
            err_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            len_q   <= '0;
            rr_q    <= '0;
`ifdef IPIF_ARB_WATCHDOG_EN
            wd_cnt_q   <= '0;
            wd_fired_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            rr_q    <= rr_d;
`ifdef IPIF_ARB_WATCHDOG_EN
            wd_cnt_q   <= wd_cnt_d;
            wd_fired_q <= wd_fired_d;
`endif
        end
    end

    assign bus.grant             = grant_q;
    assign bus.done              = done_q;
    assign bus.err               = err_q;
    assign bus.ip2bus_mstrd_req  = rd_q;
    assign bus.ip2bus_mstwr_req  = wr_q;
    assign bus.ip2bus_mst_addr   = addr_q;
    assign bus.ip2bus_mst_length = len_q;
    assign bus.busy              = (state_q != IDLE);

endmodule

// File: tb/tb_ipif_mst_cmd_arbiter.sv
// Self-checking bench for ipif_mst_cmd_arbiter: directed transactions, a
// transaction-level ownership model compared every cycle, and literal checks.
module tb_ipif_mst_cmd_arbiter;
    localparam int N   = 4;
    localparam int AW  = 32;
    localparam int LW  = 20;
    localparam int TMO = 16;
`ifdef IPIF_ARB_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    ipif_mst_cmd_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

`ifdef IPIF_ARB_WATCHDOG_EN
    logic wd_fired;
`endif

    ipif_mst_cmd_arbiter #(
        .NUM_REQ(N), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
`ifdef IPIF_ARB_WATCHDOG_EN
        ,
        .wd_fired(wd_fired)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: DUT event did not occur within bound (t=%0t)", name, $time);
    endtask

    // ---------------- ownership model ----------------
    int                owner      = -1;
    bit                posted     = 1'b0;
    bit                awaiting   = 1'b0;
    bit                reporting  = 1'b0;
    bit                m_is_rd    = 1'b0;
    int                m_rr       = 0;
    int                m_wd       = 0;
    int                mc;
    bit                m_wd_fired = 1'b0;
    bit                model_live = 1'b0;
    logic [AW-1:0]     m_addr     = '0;
    logic [LW-1:0]     m_len      = '0;
    logic [N-1:0]      m_done     = '0;
    logic [N-1:0]      m_err      = '0;

    task automatic model_finish(input bit e);
        reporting = 1'b1;
        m_done    = N'(1) << owner;
        m_err     = e ? m_done : '0;
    endtask

    always @(posedge clock) begin
        model_live = 1'b1;
        if (!reset) begin
            owner = -1; posted = 0; awaiting = 0; reporting = 0; m_is_rd = 0;
            m_rr = 0; m_wd = 0; m_wd_fired = 0; m_addr = '0; m_len = '0;
            m_done = '0; m_err = '0;
        end else if (reporting) begin
            reporting = 0; owner = -1; m_done = '0; m_err = '0;
        end else if (owner < 0) begin
            for (int k = 0; k < N; k++) begin
                mc = (m_rr + k) % N;
                if (owner < 0 && (bus.req_rd[mc] || bus.req_wr[mc])) owner = mc;
            end
            if (owner >= 0) begin
                posted  = 1;
                m_is_rd = bus.req_rd[owner];
                m_addr  = bus.req_addr[owner*AW +: AW];
                m_len   = bus.req_len[owner*LW +: LW];
                m_rr    = (owner + 1) % N;
                m_wd    = 0;
            end
        end else if (posted) begin
            if (bus.bus2ip_mst_cmdack) begin
                posted = 0;
                if (bus.bus2ip_mst_cmplt) model_finish(bus.bus2ip_mst_error);
                else begin awaiting = 1; m_wd = 0; end
            end else if (WD_EN && m_wd == TMO - 1) begin
                posted = 0; model_finish(1'b1); m_wd_fired = 1;
            end else m_wd++;
        end else if (awaiting) begin
            if (bus.bus2ip_mst_cmplt) begin
                awaiting = 0; model_finish(bus.bus2ip_mst_error);
            end else if (WD_EN && m_wd == TMO - 1) begin
                awaiting = 0; model_finish(1'b1); m_wd_fired = 1;
            end else m_wd++;
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [N-1:0] exp_grant;
    logic         prev_wr  = 1'b0;
    int           wr_rises = 0;

    always @(negedge clock) begin
        if (model_live) begin
            exp_grant = (owner >= 0) ? (N'(1) << owner) : '0;
            chk("grant",  bus.grant, exp_grant);
            chk("done",   bus.done,  m_done);
            chk("err",    bus.err,   m_err);
            chk("rd_req", bus.ip2bus_mstrd_req, posted && m_is_rd);
            chk("wr_req", bus.ip2bus_mstwr_req, posted && !m_is_rd);
            chk("addr",   bus.ip2bus_mst_addr,   m_addr);
            chk("length", bus.ip2bus_mst_length, m_len);
            chk("busy",   bus.busy, owner >= 0);
`ifdef IPIF_ARB_WATCHDOG_EN
            chk("wd_fired", wd_fired, m_wd_fired);
`endif
            if (bus.ip2bus_mstwr_req && !prev_wr) wr_rises++;
            prev_wr = bus.ip2bus_mstwr_req;
        end
    end

    // ---------------- stimulus helpers ----------------
    // Advance one clock; requesters drop their request on seeing done.
    task automatic step();
        @(posedge clock);
        #2;
        for (int i = 0; i < N; i++)
            if (bus.done[i]) begin
                bus.req_rd[i] = 1'b0;
                bus.req_wr[i] = 1'b0;
            end
    endtask

    task automatic wait_cmd();
        int tmo;
        tmo = 0;
        while (!(bus.ip2bus_mstrd_req || bus.ip2bus_mstwr_req) && tmo < 20) begin
            step();
            tmo++;
        end
        if (!(bus.ip2bus_mstrd_req || bus.ip2bus_mstwr_req)) bound_fail("wait_cmd");
    endtask

    task automatic xfer(input int ack_wait, input int cmplt_wait, input bit same, input bit e,
                        output logic [N-1:0] g, output logic ird, output logic iwr,
                        output logic [N-1:0] d, output logic [N-1:0] er);
        wait_cmd();
        g   = bus.grant;
        ird = bus.ip2bus_mstrd_req;
        iwr = bus.ip2bus_mstwr_req;
        repeat (ack_wait) step();
        bus.bus2ip_mst_cmdack = 1'b1;
        if (same) begin
            bus.bus2ip_mst_cmplt = 1'b1;
            bus.bus2ip_mst_error = e;
        end
        step();
        bus.bus2ip_mst_cmdack = 1'b0;
        bus.bus2ip_mst_cmplt  = 1'b0;
        bus.bus2ip_mst_error  = 1'b0;
        chk("req_dropped_after_ack", bus.ip2bus_mstrd_req | bus.ip2bus_mstwr_req, 0);
        if (!same) begin
            repeat (cmplt_wait) step();
            bus.bus2ip_mst_cmplt = 1'b1;
            bus.bus2ip_mst_error = e;
            step();
            bus.bus2ip_mst_cmplt = 1'b0;
            bus.bus2ip_mst_error = 1'b0;
        end
        d  = bus.done;
        er = bus.err;
    endtask

    // ---------------- directed tests ----------------
    initial begin
        logic [N-1:0] g, d, er;
        logic         ird, iwr;
        int           cnt;
        int           wr0;
        logic [N-1:0] rr_exp [5];

        rr_exp[0] = 4'h1; rr_exp[1] = 4'h2; rr_exp[2] = 4'h4; rr_exp[3] = 4'h8; rr_exp[4] = 4'h1;
        bus.req_rd = '0;
        bus.req_wr = '0;
        bus.bus2ip_mst_cmdack = 1'b0;
        bus.bus2ip_mst_cmplt  = 1'b0;
        bus.bus2ip_mst_error  = 1'b0;
        for (int i = 0; i < N; i++) begin
            bus.req_addr[i*AW +: AW] = AW'(32'h1000 * (i + 1));
            bus.req_len[i*LW +: LW]  = LW'(4 * (i + 1));
        end

        // reset state
        reset = 1'b0;
        repeat (3) step();
        chk("rst_grant", bus.grant, 0);
        chk("rst_busy",  bus.busy, 0);
        chk("rst_addr",  bus.ip2bus_mst_addr, 0);
        chk("rst_len",   bus.ip2bus_mst_length, 0);
        reset = 1'b1;
        step();

        // basic read
        bus.req_addr[0 +: AW] = 32'h190;
        bus.req_len[0 +: LW]  = 20'd10;
        bus.req_rd[0] = 1'b1;
        step();
        chk("t1_rd_req_latency", bus.ip2bus_mstrd_req, 1);
        chk("t1_wr_req",  bus.ip2bus_mstwr_req, 0);
        chk("t1_addr",    bus.ip2bus_mst_addr, 32'h190);
        chk("t1_len",     bus.ip2bus_mst_length, 10);
        chk("t1_grant",   bus.grant, 4'h1);
        xfer(2, 4, 1'b0, 1'b0, g, ird, iwr, d, er);
        chk("t1_done", d, 4'h1);
        chk("t1_err",  er, 4'h0);
        step();
        chk("t1_done_one_cycle", bus.done, 0);
        chk("t1_idle",      bus.busy, 0);
        chk("t1_addr_hold", bus.ip2bus_mst_addr, 32'h190);

        // round-robin with all four writing
        reset = 1'b0;
        step();
        reset = 1'b1;
        wr0 = wr_rises;
        bus.req_wr = 4'hF;
        for (int t = 0; t < 5; t++) begin
            xfer(0, 1, 1'b0, 1'b0, g, ird, iwr, d, er);
            chk("t2_grant_order", g, rr_exp[t]);
            chk("t2_is_write", {ird, iwr}, 2'b01);
            if (t == 0) bus.req_wr[0] = 1'b1;
        end
        step();
        chk("t2_one_wr_req_per_grant", wr_rises - wr0, 5);

        // read and write raised together; ack and cmplt in the same cycle
        bus.req_rd[2] = 1'b1;
        bus.req_wr[2] = 1'b1;
        xfer(0, 0, 1'b1, 1'b0, g, ird, iwr, d, er);
        chk("t3_grant", g, 4'h4);
        chk("t3_dir",   {ird, iwr}, 2'b10);
        chk("t3_done_next_clock", d, 4'h4);
        chk("t3_err",   er, 4'h0);

        // bus error on requester 1, requester 2 next
        bus.req_wr[1] = 1'b1;
        bus.req_wr[2] = 1'b1;
        xfer(1, 2, 1'b0, 1'b1, g, ird, iwr, d, er);
        chk("t4_grant", g, 4'h2);
        chk("t4_done",  d, 4'h2);
        chk("t4_err",   er, 4'h2);
        xfer(0, 0, 1'b0, 1'b0, g, ird, iwr, d, er);
        chk("t4_next_grant", g, 4'h4);
        chk("t4_next_err",   er, 4'h0);

        // reset in WAIT_CMPLT
        bus.req_rd[3] = 1'b1;
        wait_cmd();
        chk("t5_grant", bus.grant, 4'h8);
        bus.bus2ip_mst_cmdack = 1'b1;
        step();
        bus.bus2ip_mst_cmdack = 1'b0;
        bus.req_rd[1] = 1'b1;
        step();
        reset = 1'b0;
        step();
        chk("t5_rst_grant", bus.grant, 0);
        chk("t5_rst_done",  bus.done, 0);
        chk("t5_rst_req",   {bus.ip2bus_mstrd_req, bus.ip2bus_mstwr_req}, 0);
        chk("t5_rst_addr",  bus.ip2bus_mst_addr, 0);
        chk("t5_rst_busy",  bus.busy, 0);
        reset = 1'b1;
        step();
        chk("t5_first_grant_lowest", bus.grant, 4'h2);
        xfer(0, 1, 1'b0, 1'b0, g, ird, iwr, d, er);
        chk("t5_done1", d, 4'h2);
        xfer(0, 1, 1'b0, 1'b0, g, ird, iwr, d, er);
        chk("t5_grant3", g, 4'h8);
        chk("t5_done3",  d, 4'h8);
        step();

`ifdef IPIF_ARB_WATCHDOG_EN
        // command never acknowledged
        bus.req_wr[0] = 1'b1;
        wait_cmd();
        cnt = 0;
        while (bus.ip2bus_mstwr_req && cnt < 40) begin
            cnt++;
            step();
        end
        chk("t6_req_cycles", cnt, TMO);
        chk("t6_done", bus.done, 4'h1);
        chk("t6_err",  bus.err, 4'h1);
        chk("t6_wd_fired", wd_fired, 1);
        step();
`endif

        repeat (2) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        n_fail++;
        $display("FAIL global_timeout: bench did not complete within 100000 time units");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/ipif_mst_cmd_arbiter.md
Name: ipif_mst_cmd_arbiter

Overview:
- Shares the single AXI master IPIF command channel between NUM_REQ user-logic requesters. Example requesters: block read engine, block write engine, debug port.
- Arbitrates round-robin and latches the winner's address, length and direction.
- Drives the IPIF request/ack/complete handshake, then returns a done/error pulse to the owner.
- Sits between the user-logic controllers and the IPIF master command ports. The data streaming ports (sof/eof/src_rdy) stay with the requesters and are not routed here.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_WIDTH, 32, IPIF address width.
- LEN_WIDTH, 20, IPIF transfer length width.
- TIMEOUT_CYCLES, 1024, watchdog limit in clocks; used only with IPIF_ARB_WATCHDOG_EN.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low.
- req_rd  in  NUM_REQ  per-requester read request; held until done/error.
- req_wr  in  NUM_REQ  per-requester write request; held until done/error.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed per-requester address; requester i occupies slice i.
- req_len  in  NUM_REQ*LEN_WIDTH  packed per-requester length.
- grant  out  NUM_REQ  one-hot owner of the channel; held from issue through completion.
- done  out  NUM_REQ  one-cycle pulse to the owner on completion.
- err  out  NUM_REQ  one-cycle pulse to the owner, coincident with done, on bus error or timeout.
- ip2bus_mstrd_req  out  1  IPIF read command request.
- ip2bus_mstwr_req  out  1  IPIF write command request.
- ip2bus_mst_addr  out  ADDR_WIDTH  latched address.
- ip2bus_mst_length  out  LEN_WIDTH  latched length.
- bus2ip_mst_cmdack  in  1  command accepted.
- bus2ip_mst_cmplt  in  1  transfer complete.
- bus2ip_mst_error  in  1  transfer error; sampled with cmplt.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (reset==0 at clock edge): every output is 0 (grant, done, err, both IPIF reqs, addr, length, busy); rr_ptr = 0; state = IDLE.
- Reset asserted mid-transfer aborts with no done pulse. The IPIF is expected to be reset alongside.
- States: IDLE, ISSUE, WAIT_CMPLT, FINISH.
- IDLE:
  - Pending set p[i] = req_rd[i] | req_wr[i].
  - If p is non-zero, the winner is the first set bit searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - On the next edge:
    - grant = onehot(winner).
    - addr and length latched from the winner's slices.
    - dir = read if req_rd[winner], else write. Read wins if a requester raises both.
    - The matching ip2bus_*_req is set to 1.
    - rr_ptr = (winner+1) mod NUM_REQ.
    - State goes to ISSUE.
  - Request-to-IPIF-req latency is 1 clock.
- ISSUE:
  - ip2bus_*_req is held high until bus2ip_mst_cmdack==1. It is cleared on the edge after ack.
  - On ack, state goes to WAIT_CMPLT.
  - If cmdack and cmplt arrive in the same cycle, go directly to FINISH.
  - Latched addr/length/dir stay stable while in ISSUE, even if requester inputs change.
- WAIT_CMPLT:
  - On bus2ip_mst_cmplt==1, capture err_flag = bus2ip_mst_error and go to FINISH.
  - cmplt arriving before cmdack (in ISSUE) is ignored.
- FINISH (1 cycle):
  - done[owner] = 1 and err[owner] = err_flag for exactly this cycle.
  - grant is cleared on exit; state goes to IDLE.
  - The owner must drop its req on seeing done. A req still high in the next IDLE cycle is treated as a new request, subject to round-robin order.
- Round-robin guarantees: with all NUM_REQ requesting continuously, grants rotate 0,1,2,...,NUM_REQ-1,0.
- Arbitration occurs only in IDLE. Requests arriving mid-transfer wait for the next IDLE.
- Back-to-back turnaround: FINISH to next IPIF req is 2 clocks (FINISH, then IDLE arbitration, then req).
- IPIF address and length outputs hold their last value after completion. They are not cleared except by reset.

Optional Feature:
- Macro: IPIF_ARB_WATCHDOG_EN.
- With the macro defined:
  - A counter of $clog2(TIMEOUT_CYCLES)+1 bits is cleared on entry to ISSUE and again on entry to WAIT_CMPLT. It increments every cycle in those two states.
  - When it reaches TIMEOUT_CYCLES-1 without cmdack (ISSUE) or cmplt (WAIT_CMPLT), ip2bus_*_req is cleared. FINISH is then entered with err_flag=1, producing done and err to the owner.
  - A sticky output wd_fired (1 bit) sets on timeout and clears only on reset.
- Without the macro: there is no counter and no wd_fired port. The block waits indefinitely for cmdack/cmplt.

Test Plan:
- Basic read: req_rd[0]=1, addr0=0x190, len0=10. Required: mstrd_req=1 one clock later with addr 0x190 and length 10. Ack after 3 clocks; req drops the next clock. cmplt after 5 more clocks gives done[0] pulse of 1 cycle and err[0]=0.
- Round-robin: req_wr[0..3] all held high, each dropped on its done. Required: grant sequence 0x1,0x2,0x4,0x8, then 0x1. Exactly one ip2bus_mstwr_req per grant.
- Conflict: req_rd[2]=1 and req_wr[2]=1 simultaneously. Required: mstrd_req=1, mstwr_req stays 0. cmdack and cmplt in the same cycle yield done[2] on the next clock.
- Error: cmplt with bus2ip_mst_error=1 on requester 1's write. Required: done[1]=1 and err[1]=1 in the same cycle; next grant goes to requester 2 if pending.
- Reset mid-op: assert reset in WAIT_CMPLT. Required: all outputs 0 next edge, no done pulse, rr_ptr=0, first grant after release goes to lowest pending index.
- Watchdog (IPIF_ARB_WATCHDOG_EN, TIMEOUT_CYCLES=16): cmdack never arrives. Required: req deasserts at the 16th ISSUE cycle, done/err pulse to owner, wd_fired=1.
